// File: rtl/calc_sequencer.sv
// calc_sequencer: button conditioning plus preview/commit FSM for the
// 8-bit switch calculator; owns the accumulator and the display value.
//
// Ports:
//   CLK, RST_N           clock, async active-low reset
//   sw[WIDTH]            operand switches (CLK-synchronous)
//   btn_store_n          raw store button, active low
//   btn_add/sub/show     raw op buttons, active high
//   acc[WIDTH]           accumulator
//   disp_value[WIDTH]    registered display value
//   commit               1-cycle pulse on every acc write
//   state[3]             FSM state for debug LEDs
//   ovf                  carry/borrow of last add/sub commit
// Build option: define CALC_OVERFLOW_EN to register ovf; otherwise it is 0.
module calc_sequencer #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] sw,
   input  logic             btn_store_n,
   input  logic             btn_add,
   input  logic             btn_sub,
   input  logic             btn_show,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] disp_value,
   output logic             commit,
   output logic [2:0]       state,
   output logic             ovf
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PRE_ADD = 3'd1;
   localparam logic [2:0] S_PRE_SUB = 3'd2;
   localparam logic [2:0] S_PRE_ACC = 3'd3;
   localparam logic [2:0] S_COMMIT  = 3'd4;

   // Button bit order: 0 store_n, 1 add, 2 sub, 3 show.
   // Released level of each raw button (store_n idles high).
   localparam logic [3:0] REL_LVL = 4'b0001;

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]         w_raw;
   logic [3:0]         r_sync1;
   logic [3:0]         r_sync2;
   logic [3:0]         r_deb;
   logic [3:0][CW-1:0] r_cnt;
   logic [3:0]         w_act;
   logic [3:0]         r_act_q;
   logic [3:0]         w_press;
   logic [3:0]         w_rel;

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic             w_store;
   logic             r_op;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_disp;
   logic             r_commit;
   logic [WIDTH-1:0] w_add;
   logic [WIDTH-1:0] w_sub;

   assign w_raw = {btn_show, btn_sub, btn_add, btn_store_n};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sync1 <= REL_LVL;
         r_sync2 <= REL_LVL;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Level is accepted once it has differed from the debounced
   // value for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_deb <= REL_LVL;
         r_cnt <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == C_MAX) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Active-high view of debounced levels, then edge pulses.
   assign w_act   = r_deb ^ REL_LVL;
   assign w_press = w_act & ~r_act_q;
   assign w_rel   = ~w_act & r_act_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_act_q <= '0;
      else        r_act_q <= w_act;
   end

   assign w_add = r_acc + sw;
   assign w_sub = r_acc - sw;

   always_comb begin
      w_next  = r_state;
      w_store = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_press[0])      w_store = 1'b1;
            else if (w_press[2]) w_next  = S_PRE_SUB;
            else if (w_press[1]) w_next  = S_PRE_ADD;
            else if (w_press[3]) w_next  = S_PRE_ACC;
         end
         S_PRE_ADD: if (w_rel[1]) w_next = S_COMMIT;
         S_PRE_SUB: if (w_rel[2]) w_next = S_COMMIT;
         S_PRE_ACC: if (w_rel[3]) w_next = S_IDLE;
         S_COMMIT:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= S_IDLE;
         r_op     <= 1'b0;
         r_acc    <= '0;
         r_disp   <= '0;
         r_commit <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_commit <= w_store | (r_state == S_COMMIT);
         // r_op: 1 = subtract, fixed for the whole preview.
         if (r_state == S_IDLE && w_next == S_PRE_SUB) r_op <= 1'b1;
         if (r_state == S_IDLE && w_next == S_PRE_ADD) r_op <= 1'b0;
         if (w_store)
            r_acc <= sw;
         else if (r_state == S_COMMIT)
            r_acc <= r_op ? w_sub : w_add;
         case (r_state)
            S_PRE_ADD: r_disp <= w_add;
            S_PRE_SUB: r_disp <= w_sub;
            S_PRE_ACC: r_disp <= r_acc;
            default:   r_disp <= sw;
         endcase
      end
   end

`ifdef CALC_OVERFLOW_EN
   logic [WIDTH:0] w_add_c;
   logic           w_borrow;
   logic           r_ovf;

   assign w_add_c  = {1'b0, r_acc} + {1'b0, sw};
   assign w_borrow = r_acc < sw;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         r_ovf <= 1'b0;
      else if (r_state == S_COMMIT)
         r_ovf <= r_op ? w_borrow : w_add_c[WIDTH];
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   assign acc        = r_acc;
   assign disp_value = r_disp;
   assign commit     = r_commit;
   assign state      = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed, table-driven bench for calc_sequencer
// with DEBOUNCE_CYCLES=4.
module tb_calc_sequencer;

   localparam int W = 8;
`ifdef CALC_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         CLK;
   logic         RST_N;
   logic [W-1:0] sw;
   logic         btn_store_n;
   logic         btn_add;
   logic         btn_sub;
   logic         btn_show;
   logic [W-1:0] acc;
   logic [W-1:0] disp_value;
   logic         commit;
   logic [2:0]   state;
   logic         ovf;

   calc_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .sw(sw),
      .btn_store_n(btn_store_n), .btn_add(btn_add),
      .btn_sub(btn_sub), .btn_show(btn_show),
      .acc(acc), .disp_value(disp_value), .commit(commit),
      .state(state), .ovf(ovf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int commit_cnt = 0;
   bit commit_q = 0;
   bit dbl = 0;
   bit nonidle = 0;

   always @(negedge CLK) begin
      if (commit) commit_cnt++;
      if (commit && commit_q) dbl = 1;
      commit_q = commit;
      if (state != 3'd0) nonidle = 1;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic btn(input int op, input logic v);
      case (op)
         0: btn_store_n = ~v;
         1: btn_add     = v;
         2: btn_sub     = v;
         default: btn_show = v;
      endcase
   endtask

   typedef struct {
      int         op;
      logic [7:0] sw;
      logic [2:0] st_hold;
      logic [7:0] disp_hold;
      logic [7:0] acc_hold;
      logic [7:0] acc_end;
      int         commits;
      bit         ovf_en_end;
   } vec_t;

   vec_t tbl[11];
   int   c0;

   initial begin
      // op: 0 store, 1 add, 2 sub, 3 show
      tbl[0]  = '{0, 8'h12, 3'd0, 8'h12, 8'h12, 8'h12, 1, 1'b0};
      tbl[1]  = '{1, 8'h05, 3'd1, 8'h17, 8'h12, 8'h17, 1, 1'b0};
      tbl[2]  = '{0, 8'h03, 3'd0, 8'h03, 8'h03, 8'h03, 1, 1'b0};
      tbl[3]  = '{2, 8'h05, 3'd2, 8'hFE, 8'h03, 8'hFE, 1, 1'b1};
      tbl[4]  = '{1, 8'h02, 3'd1, 8'h00, 8'hFE, 8'h00, 1, 1'b1};
      tbl[5]  = '{3, 8'h77, 3'd3, 8'h00, 8'h00, 8'h00, 0, 1'b1};
      tbl[6]  = '{2, 8'h01, 3'd2, 8'hFF, 8'h00, 8'hFF, 1, 1'b1};
      tbl[7]  = '{1, 8'h01, 3'd1, 8'h00, 8'hFF, 8'h00, 1, 1'b1};
      tbl[8]  = '{1, 8'h10, 3'd1, 8'h10, 8'h00, 8'h10, 1, 1'b0};
      tbl[9]  = '{0, 8'hA5, 3'd0, 8'hA5, 8'hA5, 8'hA5, 1, 1'b0};
      tbl[10] = '{2, 8'h25, 3'd2, 8'h80, 8'hA5, 8'h80, 1, 1'b0};

      RST_N = 1'b0;
      sw = 8'h00;
      btn_store_n = 1'b1;
      btn_add = 1'b0;
      btn_sub = 1'b0;
      btn_show = 1'b0;
      cyc(3);
      chk("rst_acc", 32'(acc), 32'h0);
      chk("rst_disp", 32'(disp_value), 32'h0);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_commit", 32'(commit), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      RST_N = 1'b1;
      cyc(3);

      for (int i = 0; i < 11; i++) begin
         sw = tbl[i].sw;
         c0 = commit_cnt;
         btn(tbl[i].op, 1'b1);
         cyc(10);
         chk($sformatf("v%0d_state_hold", i), 32'(state),
             32'(tbl[i].st_hold));
         chk($sformatf("v%0d_disp_hold", i), 32'(disp_value),
             32'(tbl[i].disp_hold));
         chk($sformatf("v%0d_acc_hold", i), 32'(acc),
             32'(tbl[i].acc_hold));
         btn(tbl[i].op, 1'b0);
         cyc(12);
         chk($sformatf("v%0d_acc", i), 32'(acc), 32'(tbl[i].acc_end));
         chk($sformatf("v%0d_state", i), 32'(state), 32'h0);
         chk($sformatf("v%0d_disp", i), 32'(disp_value), 32'(tbl[i].sw));
         chk($sformatf("v%0d_commits", i), 32'(commit_cnt - c0),
             32'(tbl[i].commits));
         chk($sformatf("v%0d_ovf", i), 32'(ovf),
             32'(OVF_EN & tbl[i].ovf_en_end));
      end

      // Short glitches on add are filtered out.
      sw = 8'h10;
      c0 = commit_cnt;
      nonidle = 0;
      btn_add = 1'b1;
      cyc(1);
      btn_add = 1'b0;
      cyc(10);
      btn_add = 1'b1;
      cyc(3);
      btn_add = 1'b0;
      cyc(12);
      chk("glitch_nonidle", 32'(nonidle), 32'h0);
      chk("glitch_commits", 32'(commit_cnt - c0), 32'h0);
      chk("glitch_acc", 32'(acc), 32'h80);

      // Simultaneous sub+add: sub wins, add release ignored.
      c0 = commit_cnt;
      btn_add = 1'b1;
      btn_sub = 1'b1;
      cyc(10);
      chk("both_state", 32'(state), 32'h2);
      chk("both_disp", 32'(disp_value), 32'h70);
      btn_add = 1'b0;
      cyc(12);
      chk("both_state_addrel", 32'(state), 32'h2);
      chk("both_commits_addrel", 32'(commit_cnt - c0), 32'h0);
      btn_sub = 1'b0;
      cyc(12);
      chk("both_acc", 32'(acc), 32'h70);
      chk("both_commits", 32'(commit_cnt - c0), 32'h1);
      chk("both_state_end", 32'(state), 32'h0);
      chk("both_ovf", 32'(ovf), 32'h0);

      // Reset in the middle of an add preview.
      sw = 8'h05;
      btn_add = 1'b1;
      cyc(10);
      chk("rstmid_pre_state", 32'(state), 32'h1);
      c0 = commit_cnt;
      RST_N = 1'b0;
      #1;
      chk("rstmid_acc", 32'(acc), 32'h0);
      chk("rstmid_disp", 32'(disp_value), 32'h0);
      chk("rstmid_state", 32'(state), 32'h0);
      chk("rstmid_commit", 32'(commit), 32'h0);
      cyc(2);
      btn_add = 1'b0;
      cyc(2);
      RST_N = 1'b1;
      cyc(12);
      chk("rstmid_after_state", 32'(state), 32'h0);
      chk("rstmid_after_acc", 32'(acc), 32'h0);
      chk("rstmid_commits", 32'(commit_cnt - c0), 32'h0);

      chk("commit_single_cycle", 32'(dbl), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
